// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial frame receiver with XOR parity check.
// Frame: start(0), DATA_W data bits LSB first, parity bit, stop(1); line idles high.
// Bits are sampled only on the external bit_en strobe.
// Optional macro PARITY_RX_ERR_CNT_EN adds an 8-bit saturating error counter (err_cnt).
module parity_frame_rx #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
`ifdef PARITY_RX_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d, shift_in;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  // After a low stop bit, start detection is held off until rx is seen high.
  logic              wait_hi_q, wait_hi_d;

`ifdef PARITY_RX_ERR_CNT_EN
  logic [7:0]        err_cnt_q, err_cnt_d;
`endif

  // Shift-in value: new bit enters at the MSB so the first bit ends at bit 0.
  generate
    if (DATA_W > 1) begin : g_shift_wide
      assign shift_in = {rx, shift_q[DATA_W-1:1]};
    end else begin : g_shift_one
      assign shift_in = rx;
    end
  endgenerate

  // Next-state and next-output logic; everything advances only on bit_en.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    par_d     = par_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    wait_hi_d = wait_hi_q;
`ifdef PARITY_RX_ERR_CNT_EN
    err_cnt_d = err_cnt_q;
`endif
    if (bit_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (wait_hi_q) begin
            if (rx) wait_hi_d = 1'b0;
          end else if (!rx) begin
            state_d = S_DATA;
            cnt_d   = '0;
            par_d   = 1'b0;
          end
        end
        S_DATA: begin
          shift_d = shift_in;
          par_d   = par_q ^ rx;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = par_q ^ rx;
          state_d = S_STOP;
        end
        S_STOP: begin
          data_d    = shift_q;
          perr_d    = par_q ^ PARITY_ODD;
          ferr_d    = ~rx;
          valid_d   = 1'b1;
          wait_hi_d = ~rx;
          state_d   = S_IDLE;
`ifdef PARITY_RX_ERR_CNT_EN
          if (((par_q ^ PARITY_ODD) | ~rx) && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + 8'd1;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      wait_hi_q <= 1'b0;
`ifdef PARITY_RX_ERR_CNT_EN
      err_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      par_q     <= par_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      wait_hi_q <= wait_hi_d;
`ifdef PARITY_RX_ERR_CNT_EN
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != S_IDLE);
`ifdef PARITY_RX_ERR_CNT_EN
  assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: an even-parity and an odd-parity instance share one
// serial line; a frame-level model predicts every output each cycle.
module tb_parity_frame_rx;

  logic       clk = 1'b0;
  logic       rst, rx, bit_en;
  logic [7:0] data_e, data_o;
  logic       valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;
`ifdef PARITY_RX_ERR_CNT_EN
  logic [7:0] cnt_e, cnt_o;
`endif

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) u_even (
    .clk(clk), .rst(rst), .rx(rx), .bit_en(bit_en),
    .data_out(data_e), .valid(valid_e), .parity_err(perr_e),
    .frame_err(ferr_e), .busy(busy_e)
`ifdef PARITY_RX_ERR_CNT_EN
    , .err_cnt(cnt_e)
`endif
  );

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst), .rx(rx), .bit_en(bit_en),
    .data_out(data_o), .valid(valid_o), .parity_err(perr_o),
    .frame_err(ferr_o), .busy(busy_o)
`ifdef PARITY_RX_ERR_CNT_EN
    , .err_cnt(cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  bit          cmp_en = 1'b0;

  // Frame-level model state
  logic [7:0]  exp_data = '0;
  logic        exp_valid = 1'b0, exp_busy = 1'b0;
  logic        exp_perr_e = 1'b0, exp_perr_o = 1'b0, exp_ferr = 1'b0;
  int unsigned exp_cnt_e = 0, exp_cnt_o = 0;
  bit          need_high = 1'b0;
  int unsigned vt_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      if (valid_e === 1'b1) vt_q.push_back(cyc);
      chk("valid_e", {31'd0, valid_e}, {31'd0, exp_valid});
      chk("valid_o", {31'd0, valid_o}, {31'd0, exp_valid});
      chk("busy_e", {31'd0, busy_e}, {31'd0, exp_busy});
      chk("busy_o", {31'd0, busy_o}, {31'd0, exp_busy});
      chk("data_e", {24'd0, data_e}, {24'd0, exp_data});
      chk("data_o", {24'd0, data_o}, {24'd0, exp_data});
      chk("perr_e", {31'd0, perr_e}, {31'd0, exp_perr_e});
      chk("perr_o", {31'd0, perr_o}, {31'd0, exp_perr_o});
      chk("ferr_e", {31'd0, ferr_e}, {31'd0, exp_ferr});
      chk("ferr_o", {31'd0, ferr_o}, {31'd0, exp_ferr});
`ifdef PARITY_RX_ERR_CNT_EN
      chk("cnt_e", {24'd0, cnt_e}, exp_cnt_e);
      chk("cnt_o", {24'd0, cnt_o}, exp_cnt_o);
`endif
    end
  end

  // One clock: drive inputs, take the edge, then advance the model.
  task automatic tick(input logic r, input logic e, input logic rs);
    rx = r; bit_en = e; rst = rs;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    if (rs) begin
      exp_data = '0; exp_busy = 1'b0; exp_perr_e = 1'b0; exp_perr_o = 1'b0;
      exp_ferr = 1'b0; exp_cnt_e = 0; exp_cnt_o = 0; need_high = 1'b0;
    end
  endtask

  // One bit period: random gap cycles with line noise, then the strobed bit.
  task automatic send_bit(input logic b, input int unsigned maxgap);
    int unsigned g;
    g = $urandom_range(maxgap, 0);
    repeat (g) tick(1'($urandom), 1'b0, 1'b0);
    tick(b, 1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int unsigned maxgap);
    logic x;
    send_bit(1'b0, maxgap);
    exp_busy = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(d[i], maxgap);
    send_bit(p, maxgap);
    send_bit(s, maxgap);
    x = (^d) ^ p;
    exp_valid  = 1'b1;
    exp_busy   = 1'b0;
    exp_data   = d;
    exp_perr_e = x;
    exp_perr_o = ~x;
    exp_ferr   = ~s;
    if ((x | ~s) && exp_cnt_e < 255) exp_cnt_e++;
    if ((~x | ~s) && exp_cnt_o < 255) exp_cnt_o++;
    need_high = ~s;
  endtask

  // Return the line to a state where a start bit will be accepted.
  task automatic settle(input int unsigned maxgap, input int unsigned max_idle);
    if (need_high) begin
      repeat ($urandom_range(2, 0)) send_bit(1'b0, maxgap);
      send_bit(1'b1, maxgap);
      need_high = 1'b0;
    end
    repeat ($urandom_range(max_idle, 0)) send_bit(1'b1, maxgap);
  endtask

  initial begin
    logic [7:0] d;
    logic       p, s;
    rx = 1'b1; bit_en = 1'b0; rst = 1'b1;
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    cmp_en = 1'b1;
    chk("reset_data", {24'd0, data_e}, 32'h0);
    chk("reset_valid", {31'd0, valid_e}, 32'h0);
    chk("reset_busy", {31'd0, busy_e}, 32'h0);
    tick(1'b1, 1'b0, 1'b0);

    // 0xA5, even parity bit 0, good stop
    send_frame(8'hA5, 1'b0, 1'b1, 3);
    chk("a5_valid", {31'd0, valid_e}, 32'h1);
    chk("a5_data", {24'd0, data_e}, 32'hA5);
    chk("a5_perr_even", {31'd0, perr_e}, 32'h0);
    chk("a5_perr_odd", {31'd0, perr_o}, 32'h1);
    chk("a5_ferr", {31'd0, ferr_e}, 32'h0);
    chk("a5_busy", {31'd0, busy_e}, 32'h0);
    settle(3, 1);

    // 0x07 with wrong parity bit
    send_frame(8'h07, 1'b0, 1'b1, 3);
    chk("07_data", {24'd0, data_e}, 32'h07);
    chk("07_perr", {31'd0, perr_e}, 32'h1);
    chk("07_ferr", {31'd0, ferr_e}, 32'h0);
`ifdef PARITY_RX_ERR_CNT_EN
    chk("07_cnt", {24'd0, cnt_e}, 32'h1);
`endif
    settle(3, 1);

    // 0x3C with low stop bit; low bits afterwards must not start a frame
    send_frame(8'h3C, 1'b0, 1'b0, 3);
    chk("3c_data", {24'd0, data_e}, 32'h3C);
    chk("3c_perr", {31'd0, perr_e}, 32'h0);
    chk("3c_ferr", {31'd0, ferr_e}, 32'h1);
    send_bit(1'b0, 3);
    chk("3c_hold1_busy", {31'd0, busy_e}, 32'h0);
    send_bit(1'b0, 3);
    chk("3c_hold2_busy", {31'd0, busy_e}, 32'h0);
    send_bit(1'b1, 3);
    need_high = 1'b0;
    send_bit(1'b0, 3);
    exp_busy = 1'b1;
    chk("3c_restart_busy", {31'd0, busy_e}, 32'h1);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 3);
    send_bit(1'b0, 3); send_bit(1'b1, 3);
    exp_valid = 1'b1; exp_busy = 1'b0; exp_data = 8'hFF;
    exp_perr_e = 1'b0; exp_perr_o = 1'b1; exp_ferr = 1'b0;
    if (exp_cnt_o < 255) exp_cnt_o++;
    chk("ff_data", {24'd0, data_e}, 32'hFF);
    settle(3, 1);

    // Reset after four data bits of 0xFF
    send_bit(1'b0, 3);
    exp_busy = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(1'b1, 3);
    tick(1'b1, 1'b0, 1'b1);
    chk("abort_data", {24'd0, data_e}, 32'h0);
    chk("abort_busy", {31'd0, busy_e}, 32'h0);
    chk("abort_valid", {31'd0, valid_e}, 32'h0);
    chk("abort_ferr", {31'd0, ferr_e}, 32'h0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("abort_no_valid", {31'd0, valid_e}, 32'h0);
    send_frame(8'h81, 1'b0, 1'b1, 3);
    chk("81_data", {24'd0, data_e}, 32'h81);
    chk("81_perr", {31'd0, perr_e}, 32'h0);
    settle(0, 0);

    // bit_en tied high, back-to-back frames
    tick(1'b1, 1'b1, 1'b0);
    vt_q.delete();
    send_frame(8'h55, 1'b0, 1'b1, 0);
    chk("55_data", {24'd0, data_e}, 32'h55);
    send_frame(8'hAA, 1'b0, 1'b1, 0);
    chk("aa_data", {24'd0, data_e}, 32'hAA);
    chk("aa_perr", {31'd0, perr_e}, 32'h0);
    tick(1'b1, 1'b1, 1'b0);
    chk("b2b_pulses", vt_q.size(), 32'd2);
    if (vt_q.size() == 2) chk("b2b_spacing", vt_q[1] - vt_q[0], 32'd11);

    // Randomized frames with random strobe spacing and line noise
    for (int n = 0; n < 150; n++) begin
      d = 8'($urandom);
      p = ($urandom_range(3, 0) == 0) ? ~(^d) : (^d);
      s = ($urandom_range(5, 0) != 0);
      send_frame(d, p, s, 3);
      settle(3, 2);
    end

    // 300 zero frames with parity bit 0: error on the odd instance every time
    settle(0, 0);
    for (int n = 0; n < 300; n++) begin
      send_frame(8'h00, 1'b0, 1'b1, 0);
      if (n == 0 || n == 299) chk("zero_perr_odd", {31'd0, perr_o}, 32'h1);
    end
`ifdef PARITY_RX_ERR_CNT_EN
    chk("odd_cnt_sat", {24'd0, cnt_o}, 32'd255);
`endif
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
